fios_res_normalizer_3a: RTL and testbench



---
 rtl/fios_res_normalizer_3a.sv | 119 +++++++++++
 tb/tb_fios_res_normalizer_3a.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fios_res_normalizer_3a.sv
// Carry-propagating normalizer for the 3A PE chain: folds per-beat high carry parts
// into the next word and queues the WORD_COUNT+1 normalized words in an output FIFO.
module fios_res_normalizer_3a #(
  parameter int WORD_WIDTH = 17,
  parameter int WORD_COUNT = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                    clock_i,
  input  logic                    reset_i,
  input  logic                    start_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic [2*WORD_WIDTH-1:0] in_res_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [WORD_WIDTH-1:0]   out_word_o,
  output logic                    out_last_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    ovf_o
);

  localparam int W  = WORD_WIDTH;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(WORD_COUNT);

  typedef enum logic [1:0] {IDLE, ACCUM, FLUSH} state_t;

  state_t         state, state_nx;
  logic [W:0]     carry;
  logic [CW-1:0]  beat_cnt;
  logic [W+1:0]   sum;
  logic           accept, flush_push, last_beat;

  logic [W:0]     mem [FIFO_DEPTH];
  logic [AW:0]    wr_ptr, rd_ptr;
  logic           fifo_full, fifo_empty, push, pop;
  logic [W:0]     push_data;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign sum        = {2'b00, in_res_i[W-1:0]} + {1'b0, carry};
  assign accept     = (state == ACCUM) && in_valid_i && !fifo_full;
  assign flush_push = (state == FLUSH) && !fifo_full;
  assign last_beat  = (beat_cnt == CW'(WORD_COUNT - 1));

  assign push      = accept || flush_push;
  assign pop       = out_valid_o && out_ready_i;
  assign push_data = flush_push ? {1'b1, carry[W-1:0]} : {1'b0, sum[W-1:0]};

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) state <= IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start_i) state_nx = ACCUM;
      ACCUM:   if (accept && last_beat) state_nx = FLUSH;
      FLUSH:   if (!fifo_full) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    in_ready_o = (state == ACCUM) && !fifo_full;
    busy_o     = (state != IDLE);
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      carry    <= '0;
      beat_cnt <= '0;
      ovf_o    <= 1'b0;
      done_o   <= 1'b0;
    end else begin
      done_o <= flush_push;
      if (state == IDLE && start_i) begin
        carry    <= '0;
        beat_cnt <= '0;
        ovf_o    <= 1'b0;
      end else if (accept) begin
        // Next carry: this beat's high part plus the two bits spilled out of the low sum.
        carry    <= {1'b0, in_res_i[2*W-1:W]} + {{(W-1){1'b0}}, sum[W+1:W]};
        beat_cnt <= beat_cnt + CW'(1);
      end else if (flush_push && carry[W]) begin
        ovf_o <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage is not reset; the read port is gated by empty so outputs are zero after reset.
  always_ff @(posedge clock_i) begin
    if (push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  always_comb begin
    out_valid_o = !fifo_empty;
    out_word_o  = '0;
    out_last_o  = 1'b0;
    if (!fifo_empty) begin
      out_word_o = mem[rd_ptr[AW-1:0]][W-1:0];
      out_last_o = mem[rd_ptr[AW-1:0]][W];
    end
  end

endmodule

// File: tb/tb_fios_res_normalizer_3a.sv
// Directed bench: dut_a (WORD_COUNT=4, depth 16) for the functional/overflow/back-to-back/reset
// cases, dut_b (WORD_COUNT=8, depth 4) for backpressure and push/pop at full.
module tb_fios_res_normalizer_3a;

  localparam int W = 17;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic [W-1:0] w;
    logic         last;
  } vec_t;

  vec_t tab_a [10];
  vec_t tab_b [9];

  logic clk, rst;
  logic a_start, a_valid, a_irdy, a_ovalid, a_ordy, a_last, a_busy, a_done, a_ovf;
  logic [2*W-1:0] a_res;
  logic [W-1:0]   a_word;
  logic b_start, b_valid, b_irdy, b_ovalid, b_ordy, b_last, b_busy, b_done, b_ovf;
  logic [2*W-1:0] b_res;
  logic [W-1:0]   b_word;

  int checks = 0;
  int failures = 0;
  int done_cnt_a = 0;
  int done_cnt_b = 0;
  int k;
  logic hs;
  logic [W:0] got_a [$];
  logic [W:0] got_b [$];

  fios_res_normalizer_3a #(.WORD_WIDTH(W), .WORD_COUNT(4), .FIFO_DEPTH(16)) dut_a (
    .clock_i(clk), .reset_i(rst), .start_i(a_start), .in_valid_i(a_valid),
    .in_ready_o(a_irdy), .in_res_i(a_res), .out_valid_o(a_ovalid), .out_ready_i(a_ordy),
    .out_word_o(a_word), .out_last_o(a_last), .busy_o(a_busy), .done_o(a_done), .ovf_o(a_ovf)
  );

  fios_res_normalizer_3a #(.WORD_WIDTH(W), .WORD_COUNT(8), .FIFO_DEPTH(4)) dut_b (
    .clock_i(clk), .reset_i(rst), .start_i(b_start), .in_valid_i(b_valid),
    .in_ready_o(b_irdy), .in_res_i(b_res), .out_valid_o(b_ovalid), .out_ready_i(b_ordy),
    .out_word_o(b_word), .out_last_o(b_last), .busy_o(b_busy), .done_o(b_done), .ovf_o(b_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (a_ovalid && a_ordy) got_a.push_back({a_last, a_word});
    if (b_ovalid && b_ordy) got_b.push_back({b_last, b_word});
    if (a_done) done_cnt_a++;
    if (b_done) done_cnt_b++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_a(input int first, input int nb);
    int t;
    @(posedge clk); #1 a_start = 1'b1;
    @(posedge clk); #1 a_start = 1'b0;
    for (int i = 0; i < nb; i++) begin
      a_valid = 1'b1;
      a_res   = {tab_a[first+i].hi, tab_a[first+i].lo};
      t = 0;
      @(negedge clk);
      while (!a_irdy && t < 50) begin
        t++;
        @(negedge clk);
      end
      if (!a_irdy) chk("a_in_ready_timeout", 32'(a_irdy), 1);
      @(posedge clk); #1;
    end
    a_valid = 1'b0;
  endtask

  task automatic wait_done_a();
    int t;
    t = 0;
    @(negedge clk);
    while (!a_done && t < 60) begin
      t++;
      @(negedge clk);
    end
    chk("a_done_seen", 32'(a_done), 1);
    chk("a_busy_at_done", 32'(a_busy), 0);
  endtask

  task automatic drain_a(input int n);
    int t;
    t = 0;
    while (got_a.size() < n && t < 100) begin
      t++;
      @(posedge clk); #1;
    end
    chk("a_drain_count", 32'(got_a.size()), 32'(n));
  endtask

  task automatic cmp_a(input int first, input int n, input int off);
    for (int i = 0; i < n; i++) begin
      if (off + i < got_a.size()) begin
        chk($sformatf("a_word[%0d]", off + i), 32'(got_a[off+i][W-1:0]), 32'(tab_a[first+i].w));
        chk($sformatf("a_last[%0d]", off + i), 32'(got_a[off+i][W]), 32'(tab_a[first+i].last));
      end
    end
  endtask

  initial begin
    // rows 0-4: carry-chain example; rows 5-9: final carry overflows
    tab_a[0] = '{17'h00001, 17'h1FFFF, 17'h1FFFF, 1'b0};
    tab_a[1] = '{17'h00000, 17'h1FFFF, 17'h00000, 1'b0};
    tab_a[2] = '{17'h00000, 17'h00005, 17'h00006, 1'b0};
    tab_a[3] = '{17'h1FFFF, 17'h1FFFF, 17'h1FFFF, 1'b0};
    tab_a[4] = '{17'h00000, 17'h00000, 17'h1FFFF, 1'b1};
    tab_a[5] = '{17'h00000, 17'h00000, 17'h00000, 1'b0};
    tab_a[6] = '{17'h00000, 17'h00000, 17'h00000, 1'b0};
    tab_a[7] = '{17'h1FFFF, 17'h1FFFF, 17'h1FFFF, 1'b0};
    tab_a[8] = '{17'h1FFFF, 17'h1FFFF, 17'h1FFFE, 1'b0};
    tab_a[9] = '{17'h00000, 17'h00000, 17'h00000, 1'b1};
    tab_b[0] = '{17'h00000, 17'h1FFFF, 17'h1FFFF, 1'b0};
    tab_b[1] = '{17'h00000, 17'h00001, 17'h00001, 1'b0};
    tab_b[2] = '{17'h00002, 17'h00003, 17'h00003, 1'b0};
    tab_b[3] = '{17'h00000, 17'h1FFFE, 17'h00000, 1'b0};
    tab_b[4] = '{17'h00000, 17'h00004, 17'h00005, 1'b0};
    tab_b[5] = '{17'h00001, 17'h00010, 17'h00010, 1'b0};
    tab_b[6] = '{17'h00000, 17'h1FFFF, 17'h00000, 1'b0};
    tab_b[7] = '{17'h00003, 17'h00000, 17'h00001, 1'b0};
    tab_b[8] = '{17'h00000, 17'h00000, 17'h00003, 1'b1};

    rst = 1'b1;
    a_start = 0; a_valid = 0; a_ordy = 0; a_res = '0;
    b_start = 0; b_valid = 0; b_ordy = 0; b_res = '0;
    #12;
    chk("rst_in_ready", 32'(a_irdy), 0);
    chk("rst_out_valid", 32'(a_ovalid), 0);
    chk("rst_out_word", 32'(a_word), 0);
    chk("rst_out_last", 32'(a_last), 0);
    chk("rst_busy", 32'(a_busy), 0);
    chk("rst_done", 32'(a_done), 0);
    chk("rst_ovf", 32'(a_ovf), 0);
    @(posedge clk); #1 rst = 1'b0;

    // basic carry chain, no backpressure
    a_ordy = 1'b1;
    @(posedge clk); #1 a_start = 1'b1;
    @(posedge clk); #1 a_start = 1'b0;
    @(negedge clk);
    chk("a_ready_after_start", 32'(a_irdy), 1);
    chk("a_busy_after_start", 32'(a_busy), 1);
    got_a.delete();
    a_ordy = 1'b1;
    run_a(0, 4);
    wait_done_a();
    drain_a(5);
    cmp_a(0, 5, 0);
    chk("a_ovf_clean", 32'(a_ovf), 0);
    chk("a_done_count_1", 32'(done_cnt_a), 1);

    // overflow result queued, then back-to-back clean result
    got_a.delete();
    a_ordy = 1'b0;
    run_a(5, 4);
    wait_done_a();
    chk("a_ovf_set", 32'(a_ovf), 1);
    chk("a_queued_valid", 32'(a_ovalid), 1);
    repeat (2) @(negedge clk);
    chk("a_ovf_sticky", 32'(a_ovf), 1);
    run_a(0, 4);
    chk("a_ovf_cleared_by_start", 32'(a_ovf), 0);
    wait_done_a();
    chk("a_ovf_second", 32'(a_ovf), 0);
    @(posedge clk); #1 a_ordy = 1'b1;
    drain_a(10);
    cmp_a(5, 5, 0);
    cmp_a(0, 5, 5);

    // asynchronous reset in the middle of accumulation
    got_a.delete();
    a_ordy = 1'b0;
    run_a(0, 2);
    chk("a_mid_valid", 32'(a_ovalid), 1);
    chk("a_mid_busy", 32'(a_busy), 1);
    #3 rst = 1'b1;
    #1;
    chk("arst_in_ready", 32'(a_irdy), 0);
    chk("arst_out_valid", 32'(a_ovalid), 0);
    chk("arst_out_word", 32'(a_word), 0);
    chk("arst_busy", 32'(a_busy), 0);
    @(posedge clk); #1 rst = 1'b0;
    got_a.delete();
    a_ordy = 1'b1;
    run_a(0, 4);
    wait_done_a();
    drain_a(5);
    cmp_a(0, 5, 0);
    chk("a_done_count_total", 32'(done_cnt_a), 4);

    // backpressure on the depth-4 instance
    got_b.delete();
    b_ordy = 1'b0;
    @(posedge clk); #1 b_start = 1'b1;
    @(posedge clk); #1 b_start = 1'b0;
    k = 0;
    b_valid = 1'b1;
    b_res = {tab_b[0].hi, tab_b[0].lo};
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (!b_irdy) break;
      @(posedge clk); #1;
      k++;
      b_res = {tab_b[k].hi, tab_b[k].lo};
    end
    chk("b_pushes_before_stall", 32'(k), 4);
    repeat (3) @(negedge clk);
    chk("b_ready_low_full", 32'(b_irdy), 0);
    chk("b_word_held", 32'(b_word), 32'(tab_b[0].w));

    // pop at full: one pop, no push in that cycle, push lands the next cycle
    @(posedge clk); #1 b_ordy = 1'b1;
    @(posedge clk); #1 b_ordy = 1'b0;
    @(negedge clk);
    chk("b_one_pop", 32'(got_b.size()), 1);
    chk("b_ready_after_pop", 32'(b_irdy), 1);
    @(posedge clk); #1;
    k++;
    b_res = {tab_b[k].hi, tab_b[k].lo};
    @(negedge clk);
    chk("b_full_again", 32'(b_irdy), 0);

    for (int c = 0; c < 300 && got_b.size() < 9; c++) begin
      @(negedge clk);
      hs = b_valid && b_irdy;
      @(posedge clk); #1;
      if (hs) begin
        k++;
        if (k < 8) b_res = {tab_b[k].hi, tab_b[k].lo};
        else       b_valid = 1'b0;
      end
      b_ordy = ~b_ordy;
    end
    b_ordy = 1'b0;
    chk("b_beats_accepted", 32'(k), 8);
    chk("b_word_count", 32'(got_b.size()), 9);
    for (int i = 0; i < 9; i++) begin
      if (i < got_b.size()) begin
        chk($sformatf("b_word[%0d]", i), 32'(got_b[i][W-1:0]), 32'(tab_b[i].w));
        chk($sformatf("b_last[%0d]", i), 32'(got_b[i][W]), 32'(tab_b[i].last));
      end
    end
    repeat (3) @(negedge clk);
    chk("b_done_count", 32'(done_cnt_b), 1);
    chk("b_ovf", 32'(b_ovf), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
